// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end.
//   IMG_LEN        : pixels per MNIST frame (28x28)
//   PIX_SCALE      : 8-bit pixel to Q16.16 scale (255*257 = 65535 ~ 1.0)
//   NORM_MEAN_Q    : MNIST mean in Q16.16
//   NORM_INVSTD_Q  : reciprocal MNIST std in Q16.16
//   loader_state_t : image_loader FSM states
package cnn_pkg;

  localparam int unsigned IMG_LEN       = 784;
  localparam int signed   PIX_SCALE     = 257;
  localparam int signed   NORM_MEAN_Q   = 8566;
  localparam int signed   NORM_INVSTD_Q = 212710;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/pixel_norm.sv
// Combinational pixel conversion, 8-bit unsigned to signed Q16.16.
// Build option IMAGE_LOADER_NORM_EN:
//   undefined : q = p * 257
//   defined   : q = ((p * 257 - mean) * inv_std) >>> 16, 48-bit signed product
// Ports:
//   pix : unsigned 8-bit pixel in
//   q   : signed 32-bit Q16.16 out
module pixel_norm
  import cnn_pkg::*;
(
  input  logic [7:0]         pix,
  output logic signed [31:0] q
);

  logic signed [31:0] scaled;

  assign scaled = $signed({24'd0, pix}) * PIX_SCALE;

`ifdef IMAGE_LOADER_NORM_EN
  logic signed [31:0] centered;
  logic signed [47:0] prod;

  assign centered = scaled - NORM_MEAN_Q;
  assign prod     = 48'(centered) * 48'(NORM_INVSTD_Q);
  // Bits [47:16] are the arithmetic (floor) shift by 16, truncated to 32 bits.
  assign q        = prod[47:16];
`else
  assign q = scaled;
`endif

endmodule

// File: rtl/image_loader.sv
// MNIST frame ingest for the CNN datapath. Streams IMG_LEN pixels into a
// registered Q16.16 image buffer, checks framing, then releases the CNN
// (cnn_start) for RUN_CYCLES cycles before flagging result_valid until acked.
// Build option IMAGE_LOADER_NORM_EN selects mean/std normalisation in pixel_norm.
// Ports:
//   clk, rstn                   : clock, async active-low reset
//   pix_valid/pix_ready         : pixel stream handshake
//   pix_data, pix_last          : pixel value and end-of-frame marker
//   image_out[0:IMG_LEN-1]      : Q16.16 image, wired to CNN data_in
//   cnn_start                   : CNN active-low reset release
//   result_valid, result_ack    : logits ready / host has read them
//   frame_err                   : one-cycle pulse on a framing violation
module image_loader #(
  parameter int unsigned IMG_LEN    = cnn_pkg::IMG_LEN,
  parameter int unsigned RUN_CYCLES = 20000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [7:0]         pix_data,
  input  logic               pix_last,
  output logic signed [31:0] image_out [0:IMG_LEN-1],
  output logic               cnn_start,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               frame_err
);

  import cnn_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  loader_state_t      state;
  loader_state_t      state_next;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   timer;
  logic signed [31:0] pix_q;
  logic               accept;
  logic               at_last;
  logic               good_frame;
  logic               bad_frame;

  pixel_norm u_pixel_norm (
    .pix (pix_data),
    .q   (pix_q)
  );

  assign accept     = pix_valid && (state == LOAD);
  assign at_last    = (idx == LAST_IDX);
  assign good_frame = accept && pix_last && at_last;
  // Early pix_last, or the final slot reached without pix_last.
  assign bad_frame  = accept && (pix_last != at_last);

  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    case (state)
      LOAD: begin
        pix_ready = 1'b1;
        if (good_frame) state_next = RUN;
      end
      RUN:     if (timer == RUN_LAST) state_next = DONE;
      DONE:    if (result_ack) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LOAD;
    else       state <= state_next;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx          <= '0;
      timer        <= '0;
      cnn_start    <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      cnn_start    <= (state_next != LOAD);
      result_valid <= (state_next == DONE);
      frame_err    <= bad_frame;
      if (accept) begin
        if (good_frame || bad_frame) idx <= '0;
        else                         idx <= idx + CNT_W'(1);
      end
      if (good_frame)         timer <= '0;
      else if (state == RUN)  timer <= timer + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < IMG_LEN; i++) image_out[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < IMG_LEN; i++) begin
        if (accept && (idx == CNT_W'(i))) image_out[i] <= pix_q;
      end
    end
  end

endmodule

// File: doc/image_loader.md
# image_loader

Front-end ingest block for the CNN datapath. It accepts one MNIST frame as a valid/ready stream of 784 unsigned 8-bit pixels and converts each pixel to Q16.16. The pixels fill a registered 784-entry flat image buffer that drives the CNN `data_in` bus directly. Once the frame is complete and correctly framed, it releases the CNN's active-low start/reset line and holds it for a fixed run window. It then flags the logits valid until the host acknowledges.

## Interface
Parameters:
- `IMG_LEN`, 784, pixels per frame; index of last pixel is `IMG_LEN-1`.
- `RUN_CYCLES`, 20000, cycles `cnn_start` is held high before `result_valid` asserts; must be ≥ 1.
- `CNT_W`, 16, width of pixel index and run timer; must hold `max(IMG_LEN, RUN_CYCLES)`.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: reset; asynchronous, active-low.
- `pix_valid` in 1: pixel presented.
- `pix_ready` out 1: block accepts pixel; transfer on `pix_valid & pix_ready`.
- `pix_data` in 8: unsigned pixel, 0..255.
- `pix_last` in 1: marks final pixel of frame.
- `image_out` out signed 32 × [0:IMG_LEN-1]: Q16.16 image; wires to CNN `data_in`.
- `cnn_start` out 1: drives the CNN's first-stage `rstn`; 0 holds the CNN in reset.
- `result_valid` out 1: CNN logits stable and readable.
- `result_ack` in 1: host has read logits; restarts loading.
- `frame_err` out 1: one-cycle pulse on framing violation.

## Operation
- States: LOAD, RUN, DONE. Reset enters LOAD.
- LOAD:
  - `pix_ready=1`.
  - Each transfer writes the converted pixel to `image_out[idx]` and increments `idx`.
- Framing check on each transfer:
  - `pix_last=1` with `idx==IMG_LEN-1`: good frame. Go to RUN, clear `idx` and the timer.
  - `pix_last` asserted at any other index, or `idx==IMG_LEN-1` without `pix_last`: pulse `frame_err`, reset `idx` to 0, stay in LOAD.
  - On a framing violation the offending pixel is still written. Buffer contents are not cleared; the next frame overwrites them.
- RUN:
  - `pix_ready=0`, `cnn_start=1`, timer counts up.
  - After `RUN_CYCLES` cycles go to DONE.
- DONE:
  - `cnn_start=1` (logits are held only while the CNN is out of reset) and `result_valid=1`.
  - `result_ack` returns the block to LOAD.
- `result_ack` outside DONE is ignored. `pix_valid` outside LOAD is ignored; no transfer occurs since `pix_ready=0`.
- `image_out` is frozen in RUN and DONE.
- Conversion without the macro: `image_out = {16'd0, p} * 257` (0→0, 128→32896, 255→65535 ≈ 1.0).

## Timing
- Reset values:
  - `image_out` all 0, `idx` 0, timer 0, state LOAD.
  - `pix_ready` 1 once `rstn` deasserts.
  - `cnn_start` 0, `result_valid` 0, `frame_err` 0.
- All outputs are registered except `pix_ready`, which is decoded from the state register.
- Write latency: pixel accepted at edge N appears on `image_out` after edge N.
- Last good pixel accepted at edge N: `cnn_start=1` from N+1.
- `result_valid` rises exactly `RUN_CYCLES` cycles after `cnn_start` rises.
- `result_ack` sampled at edge M in DONE:
  - `cnn_start`, `result_valid` → 0 and `pix_ready` → 1 after M.
  - First new pixel can transfer at edge M+1.
- `frame_err` is high for the single cycle following the violating transfer.
- Asynchronous `rstn` low in any state:
  - Immediately returns to LOAD with all reset values.
  - `cnn_start` drops at once, resetting the CNN chain.
  - A partial frame is discarded.

## Configuration
- `IMAGE_LOADER_NORM_EN` defined: apply MNIST mean/std normalization after scaling.
  - `s = p*257 - 8566`, then `out = (s * 212710) >>> 16`.
  - 48-bit signed intermediate, arithmetic shift (floor), truncated to 32 bits.
  - Results: 0 → -27803, 255 → 184904.
- Undefined: plain `p*257`, no subtract or multiply hardware.
- Latency is identical in both builds.

## Structure
- Shared package `cnn_pkg` holds:
  - `IMG_LEN`.
  - Q16.16 constants `NORM_MEAN_Q` (8566), `NORM_INVSTD_Q` (212710), `PIX_SCALE` (257).
  - The `loader_state_t` enum {LOAD, RUN, DONE}.
- One combinational sub-module `pixel_norm` (8-bit in, signed 32-bit out) contains the macro-dependent conversion.
- The top level contains the FSM, index, timer and buffer.

## Test plan
- Reset, then stream pixels 0..255 cyclically with `pix_last` on #783:
  - `image_out[1]=257` and `image_out[255]=65535`.
  - `cnn_start` rises the cycle after the last transfer.
- `RUN_CYCLES=10` with a good frame: `result_valid` rises 10 cycles after `cnn_start`.
  - `result_ack` → `cnn_start=0` and `pix_ready=1` next cycle.
- `pix_last` on pixel #500: `frame_err` pulses once and `idx` returns to 0.
  - A subsequent full 784-pixel frame succeeds.
- Pixel #783 without `pix_last`: `frame_err` pulses and the state stays LOAD.
- Assert `rstn` low during RUN: `cnn_start` goes 0 asynchronously and `image_out` all 0.
- `IMAGE_LOADER_NORM_EN` build: pixel 0 → -27803, pixel 255 → 184904.
